rsa_core_dispatcher: RTL

RSA_CORE_DISPATCHER -- requirements
Module: rsa_core_dispatcher

---
 rtl/rsa_core_dispatcher_pkg.sv | 39 +++
 rtl/rsa_core_dispatcher_if.sv | 45 ++++
 rtl/rsa_operand_bank.sv | 47 ++++
 rtl/rsa_core_dispatcher.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/rsa_core_dispatcher_pkg.sv
// Shared encodings for the RSA core dispatcher: command word layout, opcodes,
// operand selects, broadcast core id and FSM state encoding.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RX    = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_TX    = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OP_X  = 3'd0,
    OP_E  = 3'd1,
    OP_R  = 3'd2,
    OP_R2 = 3'd3,
    OP_M  = 3'd4
  } operand_e;

  localparam logic [2:0] FN_COMPUTE = 3'd0;
  localparam logic [2:0] FN_WRITE   = 3'd1;
  localparam logic [3:0] CORE_ALL   = 4'hF;
  localparam int         T_W        = 10;

  typedef struct packed {
    logic [T_W-1:0] t;
    logic [13:0]    rsvd;
    logic [3:0]     core;
    logic [2:0]     sel;
    logic           load;
  } cmd_t;

  function automatic logic operand_ok(input logic [2:0] sel);
    return sel <= OP_M;
  endfunction

endpackage

// File: rtl/rsa_core_dispatcher_if.sv
// Host command/data channels and the per-core operand/start/done bus of the dispatcher.
// slave = dispatcher view, master = host plus cores view.
interface rsa_core_dispatcher_if #(
  parameter int DATA_W    = 1024,
  parameter int NUM_CORES = 2
);
  logic [31:0]               arm_to_fpga_cmd;
  logic                      arm_to_fpga_cmd_valid;
  logic                      arm_to_fpga_done;
  logic                      arm_to_fpga_done_read;
  logic                      arm_to_fpga_data_valid;
  logic                      arm_to_fpga_data_ready;
  logic [DATA_W-1:0]         arm_to_fpga_data;
  logic                      fpga_to_arm_data_valid;
  logic                      fpga_to_arm_data_ready;
  logic [DATA_W-1:0]         fpga_to_arm_data;
  logic [NUM_CORES-1:0]      core_start;
  logic [9:0]                core_t;
  logic [NUM_CORES*DATA_W-1:0] core_x;
  logic [NUM_CORES*DATA_W-1:0] core_e;
  logic [NUM_CORES*DATA_W-1:0] core_m;
  logic [NUM_CORES*DATA_W-1:0] core_r;
  logic [NUM_CORES*DATA_W-1:0] core_r2;
  logic [NUM_CORES-1:0]      core_done;
  logic [NUM_CORES*DATA_W-1:0] core_result;
  logic [3:0]                leds;

  modport slave (
    input  arm_to_fpga_cmd, arm_to_fpga_cmd_valid, arm_to_fpga_done_read,
    input  arm_to_fpga_data_valid, arm_to_fpga_data,
    input  fpga_to_arm_data_ready, core_done, core_result,
    output arm_to_fpga_done, arm_to_fpga_data_ready,
    output fpga_to_arm_data_valid, fpga_to_arm_data,
    output core_start, core_t, core_x, core_e, core_m, core_r, core_r2, leds
  );

  modport master (
    output arm_to_fpga_cmd, arm_to_fpga_cmd_valid, arm_to_fpga_done_read,
    output arm_to_fpga_data_valid, arm_to_fpga_data,
    output fpga_to_arm_data_ready, core_done, core_result,
    input  arm_to_fpga_done, arm_to_fpga_data_ready,
    input  fpga_to_arm_data_valid, fpga_to_arm_data,
    input  core_start, core_t, core_x, core_e, core_m, core_r, core_r2, leds
  );
endinterface

// File: rtl/rsa_operand_bank.sv
// Operand registers (X, E, R, R2, M) of one exponentiation core; one write port,
// write lands on the clock edge after i_wr_vld, no backpressure.
module rsa_operand_bank
  import rsa_pkg::*;
#(
  parameter int DATA_W = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_wr_vld,
  input  operand_e          i_wr_sel,
  input  logic [DATA_W-1:0] i_wr_dat,
  output logic [DATA_W-1:0] o_x,
  output logic [DATA_W-1:0] o_e,
  output logic [DATA_W-1:0] o_r,
  output logic [DATA_W-1:0] o_r2,
  output logic [DATA_W-1:0] o_m
);

  logic [DATA_W-1:0] r_x, r_e, r_r, r_r2, r_m;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x  <= '0;
      r_e  <= '0;
      r_r  <= '0;
      r_r2 <= '0;
      r_m  <= '0;
    end else if (i_wr_vld) begin
      case (i_wr_sel)
        OP_X:    r_x  <= i_wr_dat;
        OP_E:    r_e  <= i_wr_dat;
        OP_R:    r_r  <= i_wr_dat;
        OP_R2:   r_r2 <= i_wr_dat;
        OP_M:    r_m  <= i_wr_dat;
        default: ;
      endcase
    end
  end

  assign o_x  = r_x;
  assign o_e  = r_e;
  assign o_r  = r_r;
  assign o_r2 = r_r2;
  assign o_m  = r_m;

endmodule

// File: rtl/rsa_core_dispatcher.sv
// Host-command dispatcher for NUM_CORES modular-exponentiation cores: loads operands,
// starts cores and waits for their done pulses, returns results; host holds off via ready/done_read.
module rsa_core_dispatcher
  import rsa_pkg::*;
#(
  parameter int DATA_W    = 1024,
  parameter int NUM_CORES = 2
) (
  input logic                 clk,
  input logic                 resetn,
  rsa_core_dispatcher_if.slave bus
);

  state_e                    r_state, w_state_nxt;
  logic [3:0]                r_core;
  operand_e                  r_sel;
  logic                      r_err;
  logic [NUM_CORES-1:0]      r_pend;
  logic [T_W-1:0]            r_core_t;

  cmd_t                      w_cmd;
  logic                      w_core_ok;
  logic                      w_bcast;
  state_e                    w_dec_state;
  logic                      w_dec_err;
  logic                      w_accept;
  logic                      w_wr_vld;
  logic [NUM_CORES-1:0]      w_start_mask;
  logic [NUM_CORES-1:0]      w_pend_nxt;
  logic [DATA_W-1:0]         w_result_sel;
  logic                      w_data_rdy;
  logic                      w_tx_vld;
  logic [DATA_W-1:0]         w_tx_dat;
  logic                      w_done;
  logic [NUM_CORES-1:0]      w_core_start;
  logic [NUM_CORES*DATA_W-1:0] w_core_x, w_core_e, w_core_r, w_core_r2, w_core_m;
  logic                      w_unused;

  // Command decode; anything not a legal load/compute/write lands in DONE with the error flag.
  always_comb begin
    w_cmd       = cmd_t'(bus.arm_to_fpga_cmd);
    w_core_ok   = int'(w_cmd.core) < NUM_CORES;
    w_bcast     = (w_cmd.core == CORE_ALL);
    w_dec_state = ST_DONE;
    w_dec_err   = 1'b1;
    if (w_cmd.load) begin
      if (w_core_ok && operand_ok(w_cmd.sel)) begin
        w_dec_state = ST_RX;
        w_dec_err   = 1'b0;
      end
    end else if (w_cmd.sel == FN_COMPUTE) begin
      if (w_core_ok || w_bcast) begin
        w_dec_state = ST_START;
        w_dec_err   = 1'b0;
      end
    end else if (w_cmd.sel == FN_WRITE) begin
      if (w_core_ok) begin
        w_dec_state = ST_TX;
        w_dec_err   = 1'b0;
      end
    end
  end

  assign w_unused   = ^w_cmd.rsvd;
  assign w_accept   = (r_state == ST_IDLE) && bus.arm_to_fpga_cmd_valid;
  assign w_wr_vld   = (r_state == ST_RX) && bus.arm_to_fpga_data_valid;
  assign w_pend_nxt = r_pend & ~bus.core_done;

  always_comb begin
    w_start_mask = '0;
    w_result_sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_start_mask[i] = (r_core == CORE_ALL) || (r_core == 4'(i));
      if (r_core == 4'(i)) w_result_sel = bus.core_result[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.arm_to_fpga_cmd_valid) w_state_nxt = w_dec_state;
      ST_RX:    if (bus.arm_to_fpga_data_valid) w_state_nxt = ST_DONE;
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_pend_nxt == '0) w_state_nxt = ST_DONE;
      ST_TX:    if (bus.fpga_to_arm_data_ready) w_state_nxt = ST_DONE;
      ST_DONE:  if (bus.arm_to_fpga_done_read) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_data_rdy   = 1'b0;
    w_tx_vld     = 1'b0;
    w_tx_dat     = '0;
    w_done       = 1'b0;
    w_core_start = '0;
    case (r_state)
      ST_RX:    w_data_rdy = 1'b1;
      ST_START: w_core_start = w_start_mask;
      ST_TX: begin
        w_tx_vld = 1'b1;
        w_tx_dat = w_result_sel;
      end
      ST_DONE:  w_done = 1'b1;
      default:  ;
    endcase
  end

  // core_t is captured on accept so it is already stable while the start pulse is out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_core   <= '0;
      r_sel    <= OP_X;
      r_err    <= 1'b0;
      r_pend   <= '0;
      r_core_t <= '0;
    end else begin
      if (w_accept) begin
        r_core <= w_cmd.core;
        r_sel  <= operand_e'(w_cmd.sel);
        r_err  <= w_dec_err;
        if (w_dec_state == ST_START) r_core_t <= w_cmd.t;
      end
      if (r_state == ST_START)     r_pend <= w_start_mask;
      else if (r_state == ST_WAIT) r_pend <= w_pend_nxt;
    end
  end

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_bank
    rsa_operand_bank #(.DATA_W(DATA_W)) u_bank (
      .clk      (clk),
      .resetn   (resetn),
      .i_wr_vld (w_wr_vld && (r_core == 4'(gi))),
      .i_wr_sel (r_sel),
      .i_wr_dat (bus.arm_to_fpga_data),
      .o_x      (w_core_x[gi*DATA_W +: DATA_W]),
      .o_e      (w_core_e[gi*DATA_W +: DATA_W]),
      .o_r      (w_core_r[gi*DATA_W +: DATA_W]),
      .o_r2     (w_core_r2[gi*DATA_W +: DATA_W]),
      .o_m      (w_core_m[gi*DATA_W +: DATA_W])
    );
  end

  assign bus.arm_to_fpga_data_ready = w_data_rdy;
  assign bus.arm_to_fpga_done       = w_done;
  assign bus.fpga_to_arm_data_valid = w_tx_vld;
  assign bus.fpga_to_arm_data       = w_tx_dat;
  assign bus.core_start             = w_core_start;
  assign bus.core_t                 = r_core_t;
  assign bus.core_x                 = w_core_x;
  assign bus.core_e                 = w_core_e;
  assign bus.core_r                 = w_core_r;
  assign bus.core_r2                = w_core_r2;
  assign bus.core_m                 = w_core_m;
  assign bus.leds                   = {r_err, r_state != ST_IDLE, |r_pend, r_state == ST_DONE};

endmodule
